vga_pattern: RTL and testbench

VGA_PATTERN -- requirements
Module: vga_pattern

---
 rtl/vga_pattern.sv | 196 +++++++++++++++++++
 tb/tb_vga_pattern.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pattern.sv
// Test-pattern generator that sits behind a VGA sync generator.
// It takes the raw counts and sync signals and produces a 2-stage registered
// colour path: colour bars, checkerboard, gradient or solid colour.
// A bouncing box can be drawn over the pattern.
module vga_pattern #(
  parameter logic [9:0] HDISP = 10'd640,
  parameter logic [9:0] VDISP = 10'd480,
  parameter logic [9:0] BOX   = 10'd32
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [9:0] hcount_i,
  input  logic [9:0] vcount_i,
  input  logic       hs_i,
  input  logic       vs_i,
  input  logic [1:0] mode_i,
  input  logic       box_en_i,
  output logic [3:0] vga_r_o,
  output logic [3:0] vga_g_o,
  output logic [3:0] vga_b_o,
  output logic       vga_hs_o,
  output logic       vga_vs_o,
  output logic       frame_tick_o
);

  localparam logic [9:0] BarW  = HDISP / 10'd8;
  localparam logic [9:0] BxMax = HDISP - BOX;
  localparam logic [9:0] ByMax = VDISP - BOX;

  // Stage 1 registers
  logic [9:0] hc_q;
  logic [3:0] vc_hi_q;  // vcount[7:4]: all the colour logic needs vertically
  logic       active_q, hit_q, box_en_q, hs1_q, vs1_q;
  // Stage 2 registers (drive the outputs directly)
  logic [3:0] r_q, g_q, b_q;
  logic [3:0] r_d, g_d, b_d;
  logic       hs2_q, vs2_q;
  // Frame-rate state
  logic       frame_tick_q;
  logic [1:0] mode_q;
  logic [9:0] bx_q, by_q, bx_d, by_d;
  logic       dx_q, dy_q, dx_d, dy_d;

  logic        active_d, hit_d, frame_evt;
  logic [10:0] bx_end, by_end;
  logic [2:0]  bar_idx;

  assign active_d  = (hcount_i < HDISP) && (vcount_i < VDISP);
  assign frame_evt = (hcount_i == 10'd0) && (vcount_i == VDISP);

  // 11-bit box extent so the far edge cannot wrap around zero
  assign bx_end = {1'b0, bx_q} + {1'b0, BOX};
  assign by_end = {1'b0, by_q} + {1'b0, BOX};
  assign hit_d  = (hcount_i >= bx_q) && ({1'b0, hcount_i} < bx_end) &&
                  (vcount_i >= by_q) && ({1'b0, vcount_i} < by_end);

  // Stage 1: capture counts, active flag, box hit and sync
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      hc_q     <= '0;
      vc_hi_q  <= '0;
      active_q <= 1'b0;
      hit_q    <= 1'b0;
      box_en_q <= 1'b0;
      hs1_q    <= 1'b0;
      vs1_q    <= 1'b0;
    end else begin
      hc_q     <= hcount_i;
      vc_hi_q  <= vcount_i[7:4];
      active_q <= active_d;
      hit_q    <= hit_d;
      box_en_q <= box_en_i;
      hs1_q    <= hs_i;
      vs1_q    <= vs_i;
    end
  end

  // Colour-bar index: count the bar boundaries at or left of the pixel
  always_comb begin
    logic [10:0] bar_edge;
    bar_idx  = '0;
    bar_edge = {1'b0, BarW};
    for (int k = 1; k < 8; k++) begin
      if ({1'b0, hc_q} >= bar_edge) bar_idx = bar_idx + 3'd1;
      bar_edge = bar_edge + {1'b0, BarW};
    end
  end

  // Pattern select, box overlay and blanking
  always_comb begin
    r_d = '0;
    g_d = '0;
    b_d = '0;
    if (active_q) begin
      if (box_en_q && hit_q) begin
        {r_d, g_d, b_d} = 12'hFFF;
      end else begin
        unique case (mode_q)
          2'd0: begin
            r_d = {4{bar_idx[2]}};
            g_d = {4{bar_idx[1]}};
            b_d = {4{bar_idx[0]}};
          end
          2'd1: begin
            if (hc_q[5] ^ vc_hi_q[1]) {r_d, g_d, b_d} = 12'hFFF;
          end
          2'd2: begin
            r_d = hc_q[7:4];
            g_d = vc_hi_q;
          end
          default: {r_d, g_d, b_d} = 12'h888;
        endcase
      end
    end
  end

  // Stage 2: register colour and the twice-delayed sync
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_q   <= '0;
      g_q   <= '0;
      b_q   <= '0;
      hs2_q <= 1'b0;
      vs2_q <= 1'b0;
    end else begin
      r_q   <= r_d;
      g_q   <= g_d;
      b_q   <= b_d;
      hs2_q <= hs1_q;
      vs2_q <= vs1_q;
    end
  end

  // Box step on each frame event; bounces at the edges without overshoot
  always_comb begin
    bx_d = bx_q;
    dx_d = dx_q;
    by_d = by_q;
    dy_d = dy_q;
    if (frame_evt) begin
      if (dx_q) begin
        if (bx_q >= BxMax) begin
          dx_d = 1'b0;
          bx_d = bx_q - 10'd1;
        end else begin
          bx_d = bx_q + 10'd1;
        end
      end else if (bx_q == 10'd0) begin
        dx_d = 1'b1;
        bx_d = 10'd1;
      end else begin
        bx_d = bx_q - 10'd1;
      end
      if (dy_q) begin
        if (by_q >= ByMax) begin
          dy_d = 1'b0;
          by_d = by_q - 10'd1;
        end else begin
          by_d = by_q + 10'd1;
        end
      end else if (by_q == 10'd0) begin
        dy_d = 1'b1;
        by_d = 10'd1;
      end else begin
        by_d = by_q - 10'd1;
      end
    end
  end

  // Frame-rate state: tick, mode latch and box position
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      frame_tick_q <= 1'b0;
      mode_q       <= '0;
      bx_q         <= '0;
      by_q         <= '0;
      dx_q         <= 1'b1;
      dy_q         <= 1'b1;
    end else begin
      frame_tick_q <= frame_evt;
      if (frame_evt) mode_q <= mode_i;
      bx_q <= bx_d;
      by_q <= by_d;
      dx_q <= dx_d;
      dy_q <= dy_d;
    end
  end

  assign vga_r_o      = r_q;
  assign vga_g_o      = g_q;
  assign vga_b_o      = b_q;
  assign vga_hs_o     = hs2_q;
  assign vga_vs_o     = vs2_q;
  assign frame_tick_o = frame_tick_q;

endmodule

// File: tb/tb_vga_pattern.sv
// Directed bench for vga_pattern. Expected pixels are pushed to a queue as
// inputs are driven and popped once the 2-cycle pipeline produces them.
module tb_vga_pattern;

  logic       clk = 1'b0;
  logic       rst;
  logic [9:0] hcount, vcount;
  logic       hs, vs, box_en;
  logic [1:0] mode;
  logic [3:0] vga_r, vga_g, vga_b;
  logic       vga_hs, vga_vs, frame_tick;

  int checks = 0;
  int errors = 0;
  int ticks  = 0;
  int events = 0;

  // Reference model state
  int         bx_m, by_m;
  logic       dx_m, dy_m;
  logic [1:0] mode_m;
  logic [13:0] exp_q[$];

  always #5 clk = ~clk;

  vga_pattern dut (
    .clk_i        (clk),
    .rst_i        (rst),
    .hcount_i     (hcount),
    .vcount_i     (vcount),
    .hs_i         (hs),
    .vs_i         (vs),
    .mode_i       (mode),
    .box_en_i     (box_en),
    .vga_r_o      (vga_r),
    .vga_g_o      (vga_g),
    .vga_b_o      (vga_b),
    .vga_hs_o     (vga_hs),
    .vga_vs_o     (vga_vs),
    .frame_tick_o (frame_tick)
  );

  always @(negedge clk) if (!rst && frame_tick) ticks++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  function automatic logic [11:0] model_rgb(input int h, input int v, input logic ben);
    int idx;
    logic [3:0] r, g, b;
    if (!(h < 640 && v < 480)) return 12'h000;
    if (ben && h >= bx_m && h < bx_m + 32 && v >= by_m && v < by_m + 32) return 12'hFFF;
    case (mode_m)
      2'd0: begin
        idx = h / 80;
        r = ((idx & 4) != 0) ? 4'hF : 4'h0;
        g = ((idx & 2) != 0) ? 4'hF : 4'h0;
        b = ((idx & 1) != 0) ? 4'hF : 4'h0;
        return {r, g, b};
      end
      2'd1: return ((((h >> 5) ^ (v >> 5)) & 1) != 0) ? 12'hFFF : 12'h000;
      2'd2: return {4'((h >> 4) & 15), 4'((v >> 4) & 15), 4'h0};
      default: return 12'h888;
    endcase
  endfunction

  task automatic model_frame(input logic [1:0] md);
    mode_m = md;
    if (dx_m) begin
      if (bx_m == 608) begin dx_m = 1'b0; bx_m = bx_m - 1; end
      else bx_m = bx_m + 1;
    end else if (bx_m == 0) begin dx_m = 1'b1; bx_m = 1; end
    else bx_m = bx_m - 1;
    if (dy_m) begin
      if (by_m == 448) begin dy_m = 1'b0; by_m = by_m - 1; end
      else by_m = by_m + 1;
    end else if (by_m == 0) begin dy_m = 1'b1; by_m = 1; end
    else by_m = by_m - 1;
  endtask

  // One pixel clock: drive, push expectation, clock, compare what emerges
  task automatic step(input int h, input int v, input logic hs_v, input logic vs_v,
                      input logic [1:0] md, input logic ben);
    logic        evt;
    logic [13:0] e;
    hcount = 10'(h);
    vcount = 10'(v);
    hs     = hs_v;
    vs     = vs_v;
    mode   = md;
    box_en = ben;
    e = {model_rgb(h, v, ben), hs_v, vs_v};
    exp_q.push_back(e);
    evt = (h == 0 && v == 480);
    @(posedge clk);
    #1;
    if (evt) begin
      model_frame(md);
      events++;
    end
    if (exp_q.size() >= 2) begin
      e = exp_q.pop_front();
      check("pixel", {18'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs}, {18'd0, e});
    end
    check("frame_tick", {31'd0, frame_tick}, {31'd0, evt});
  endtask

  // Raise reset between edges, confirm asynchronous clear, then release
  task automatic apply_reset();
    rst = 1'b1;
    #2;
    check("rst_async_out", {17'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_tick}, 32'd0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_held_out", {17'd0, vga_r, vga_g, vga_b, vga_hs, vga_vs, frame_tick}, 32'd0);
    check("rst_state", {10'd0, dut.bx_q, dut.by_q, dut.mode_q}, 32'd0);
    check("rst_dir", {30'd0, dut.dx_q, dut.dy_q}, 32'd3);
    rst    = 1'b0;
    bx_m   = 0;
    by_m   = 0;
    dx_m   = 1'b1;
    dy_m   = 1'b1;
    mode_m = 2'd0;
    exp_q.delete();
    exp_q.push_back(14'd0);  // stage 1 holds reset values
  endtask

  initial begin
    rst = 1'b0; hcount = '0; vcount = '0; hs = 1'b0; vs = 1'b0;
    mode = 2'd0; box_en = 1'b0;
    #1;
    apply_reset();

    // Colour bars: blue bar, white bar, sweep across the line
    for (int h = 80; h < 160; h++) step(h, 10, 0, 0, 0, 0);
    step(560, 10, 0, 0, 0, 0);
    for (int h = 0; h < 640; h += 37) step(h, 200, 0, 0, 0, 0);

    // Blanking and a 96-cycle HS pulse
    step(700, 10, 0, 0, 3, 0);
    step(100, 500, 0, 1, 3, 0);
    for (int i = 0; i < 96; i++) step(656 + i, 20, 1, 0, 3, 0);
    for (int i = 0; i < 4; i++) step(752 + i, 20, 0, 0, 3, 0);

    // Box overlay at BX=BY=0
    step(31, 31, 0, 0, 0, 1);
    step(32, 31, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(31, 32, 0, 0, 0, 1);
    step(31, 31, 0, 0, 0, 0);

    // Mid-frame mode change holds until the frame event
    step(500, 300, 0, 0, 0, 0);
    step(500, 301, 0, 0, 2, 0);
    step(100, 302, 0, 0, 2, 0);
    step(700, 479, 0, 0, 2, 0);
    step(0, 480, 0, 1, 2, 0);
    step(0, 0, 0, 0, 2, 0);
    step(255, 255, 0, 0, 2, 0);
    step(700, 0, 0, 0, 2, 0);

    // Checkerboard frame
    step(0, 480, 0, 1, 1, 0);
    step(0, 0, 0, 0, 1, 0);
    step(32, 0, 0, 0, 1, 0);
    step(32, 32, 0, 0, 1, 0);
    step(10, 40, 0, 0, 1, 0);
    step(700, 0, 0, 0, 1, 0);

    // Solid frame
    step(0, 480, 0, 1, 3, 0);
    step(10, 10, 0, 0, 3, 0);
    step(639, 479, 0, 0, 3, 0);
    step(700, 0, 0, 0, 3, 0);

    // Box motion over 700 frames from a fresh reset
    apply_reset();
    ticks  = 0;
    events = 0;
    for (int f = 1; f <= 700; f++) begin
      step(0, 480, 0, 1, 3, 0);
      step(700, 490, 0, 0, 3, 0);
      if (f == 608) begin
        check("bx_at_608", {22'd0, dut.bx_q}, 32'd608);
        check("dx_at_608", {31'd0, dut.dx_q}, 32'd1);
      end
      if (f == 609) begin
        check("bx_at_609", {22'd0, dut.bx_q}, 32'd607);
        check("dx_at_609", {31'd0, dut.dx_q}, 32'd0);
      end
      if (f == 448) check("by_at_448", {22'd0, dut.by_q}, 32'd448);
      if (f == 449) begin
        check("by_at_449", {22'd0, dut.by_q}, 32'd447);
        check("dy_at_449", {31'd0, dut.dy_q}, 32'd0);
      end
      if (f == 100 || f == 620) begin
        step(bx_m, by_m, 0, 0, 3, 1);
        step(bx_m + 32, by_m, 0, 0, 3, 1);
        step(bx_m + 31, by_m + 31, 0, 0, 3, 1);
        step(700, 490, 0, 0, 3, 0);
      end
    end
    check("bx_final", {22'd0, dut.bx_q}, 32'd516);
    check("by_final", {22'd0, dut.by_q}, 32'd196);
    check("tick_count", 32'(ticks), 32'd700);

    // Asynchronous reset mid-line, then resume with 2-cycle latency
    step(100, 100, 0, 0, 3, 0);
    step(101, 100, 0, 0, 3, 0);
    step(102, 100, 0, 0, 3, 0);
    apply_reset();
    step(560, 10, 0, 0, 0, 0);
    step(80, 10, 1, 0, 0, 0);
    step(300, 10, 0, 1, 0, 0);
    step(700, 10, 0, 0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
